// File: rtl/register_file_pkg.sv
// Shared encodings for the register file: FunSel operation codes and read-select codes.
package register_file_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  localparam logic [2:0] SEL_R1 = 3'b000;
  localparam logic [2:0] SEL_R2 = 3'b001;
  localparam logic [2:0] SEL_R3 = 3'b010;
  localparam logic [2:0] SEL_R4 = 3'b011;
  localparam logic [2:0] SEL_S1 = 3'b100;
  localparam logic [2:0] SEL_S2 = 3'b101;
  localparam logic [2:0] SEL_S3 = 3'b110;
  localparam logic [2:0] SEL_S4 = 3'b111;

  localparam int unsigned NumRegs = 8;

endpackage

// File: rtl/gp_reg.sv
// Single general-purpose register: decrement, increment, load or clear when enabled.
module gp_reg
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (E) begin
      case (FunSel)
        FS_DEC:  q_d = q_q - WIDTH'(1);
        FS_INC:  q_d = q_q + WIDTH'(1);
        FS_LOAD: q_d = I;
        FS_CLR:  q_d = '0;
        default: q_d = q_q;
      endcase
    end
  end

  // Reset wins over any operation requested on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/register_file.sv
// Eight-entry register file (R1..R4, S1..S4) with shared operation and two combinational read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [1:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  logic [NumRegs-1:0] reg_en;
  logic [WIDTH-1:0]   regs [NumRegs];

  // Enable index matches the read-select code: R1..R4 then S1..S4.
  assign reg_en = {ScrSel, RegSel};

  for (genvar k = 0; k < NumRegs; k++) begin : g_regs
    gp_reg #(
      .WIDTH (WIDTH)
    ) u_gp_reg (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (reg_en[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (regs[k])
    );
  end

  assign OutA = regs[OutASel];
  assign OutB = regs[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, hand-written corner sequences, random vs. model.
module tb_register_file;

  localparam int unsigned W = 16;

  logic         Clock;
  logic         Reset;
  logic [W-1:0] I;
  logic [1:0]   FunSel;
  logic [3:0]   RegSel;
  logic [3:0]   ScrSel;
  logic [2:0]   OutASel;
  logic [2:0]   OutBSel;
  logic [W-1:0] OutA;
  logic [W-1:0] OutB;

  register_file #(
    .WIDTH (W)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic         rst;
    logic [1:0]   fun;
    logic [3:0]   rs;
    logic [3:0]   ss;
    logic [W-1:0] din;
    logic [2:0]   asel;
    logic [2:0]   bsel;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  vec_t         vecs [12];
  logic [W-1:0] model [8];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Reference behaviour: every enabled register applies the op, arithmetic wraps at 2^16.
  function automatic void model_apply(input logic rst, input logic [1:0] fun,
                                      input logic [3:0] rs, input logic [3:0] ss,
                                      input logic [W-1:0] din);
    logic [7:0] en;
    en = {ss, rs};
    for (int k = 0; k < 8; k++) begin
      if (rst) model[k] = '0;
      else if (en[k]) begin
        case (fun)
          2'd0: model[k] = W'((int'(model[k]) + 65535) % 65536);
          2'd1: model[k] = W'((int'(model[k]) + 1) % 65536);
          2'd2: model[k] = din;
          default: model[k] = '0;
        endcase
      end
    end
  endfunction

  task automatic do_cycle(input logic rst, input logic [1:0] fun, input logic [3:0] rs,
                          input logic [3:0] ss, input logic [W-1:0] din);
    Reset  = rst;
    FunSel = fun;
    RegSel = rs;
    ScrSel = ss;
    I      = din;
    @(posedge Clock);
    model_apply(rst, fun, rs, ss, din);
    #1;
    Reset  = 1'b0;
    RegSel = 4'h0;
    ScrSel = 4'h0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [2:0] b,
                            input logic [W-1:0] ea, input logic [W-1:0] eb);
    OutASel = a;
    OutBSel = b;
    #1;
    check({name, ".A"}, OutA, ea);
    check({name, ".B"}, OutB, eb);
  endtask

  initial begin
    Reset = 1'b1; FunSel = 2'd0; RegSel = 4'h0; ScrSel = 4'h0; I = '0;
    OutASel = 3'd0; OutBSel = 3'd0;
    for (int k = 0; k < 8; k++) model[k] = '0;

    //            rst   fun    rs     ss     din       asel    bsel    ea        eb
    vecs[0]  = '{1'b1, 2'd1, 4'hF, 4'hF, 16'h5555, 3'd0, 3'd7, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 2'd2, 4'h1, 4'h0, 16'h1234, 3'd0, 3'd4, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b0, 2'd0, 4'h2, 4'h0, 16'h9999, 3'd1, 3'd0, 16'hFFFF, 16'h1234};
    vecs[3]  = '{1'b0, 2'd1, 4'h2, 4'h0, 16'h9999, 3'd1, 3'd0, 16'h0000, 16'h1234};
    vecs[4]  = '{1'b0, 2'd2, 4'hF, 4'hF, 16'hA5A5, 3'd3, 3'd7, 16'hA5A5, 16'hA5A5};
    vecs[5]  = '{1'b0, 2'd3, 4'h0, 4'h4, 16'h0000, 3'd6, 3'd5, 16'h0000, 16'hA5A5};
    vecs[6]  = '{1'b0, 2'd2, 4'h0, 4'h1, 16'h0010, 3'd4, 3'd0, 16'h0010, 16'hA5A5};
    vecs[7]  = '{1'b1, 2'd1, 4'h0, 4'h1, 16'h0000, 3'd4, 3'd3, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b0, 2'd2, 4'h0, 4'h0, 16'hFFFF, 3'd0, 3'd4, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b0, 2'd0, 4'h4, 4'h0, 16'h0000, 3'd2, 3'd2, 16'hFFFF, 16'hFFFF};
    vecs[10] = '{1'b0, 2'd1, 4'h4, 4'h8, 16'h0000, 3'd2, 3'd7, 16'h0000, 16'h0001};
    vecs[11] = '{1'b0, 2'd1, 4'h4, 4'h8, 16'h0000, 3'd2, 3'd7, 16'h0001, 16'h0002};

    @(negedge Clock);
    for (int v = 0; v < 12; v++) begin
      do_cycle(vecs[v].rst, vecs[v].fun, vecs[v].rs, vecs[v].ss, vecs[v].din);
      read_check($sformatf("vec%0d", v), vecs[v].asel, vecs[v].bsel, vecs[v].ea, vecs[v].eb);
    end

    // All eight registers loaded, one scratch cleared, others keep value.
    do_cycle(1'b0, 2'd2, 4'hF, 4'hF, 16'hA5A5);
    do_cycle(1'b0, 2'd3, 4'h0, 4'h4, 16'h0000);
    for (int s = 0; s < 8; s++)
      read_check($sformatf("clr_s3_sel%0d", s), 3'(s), 3'(7 - s),
                 (s == 6) ? 16'h0000 : 16'hA5A5, (7 - s == 6) ? 16'h0000 : 16'hA5A5);

    // Random loads, then one reset edge: every select reads zero.
    for (int k = 0; k < 4; k++)
      do_cycle(1'b0, 2'd2, 4'($urandom), 4'($urandom), 16'($urandom | 1));
    do_cycle(1'b1, 2'd2, 4'hF, 4'hF, 16'h7777);
    for (int s = 0; s < 8; s++)
      read_check($sformatf("post_reset_sel%0d", s), 3'(s), 3'(s), 16'h0000, 16'h0000);

    // No write-through: both ports show the old R4 until the edge has passed.
    do_cycle(1'b0, 2'd2, 4'h8, 4'h0, 16'h00FF);
    OutASel = 3'd3; OutBSel = 3'd3;
    Reset = 1'b0; FunSel = 2'd2; RegSel = 4'h8; ScrSel = 4'h0; I = 16'hBEEF;
    #1;
    check("r4_before_edge.A", OutA, 16'h00FF);
    check("r4_before_edge.B", OutB, 16'h00FF);
    @(posedge Clock);
    model_apply(1'b0, 2'd2, 4'h8, 4'h0, 16'hBEEF);
    #1;
    RegSel = 4'h0;
    check("r4_after_edge.A", OutA, 16'hBEEF);
    check("r4_after_edge.B", OutB, 16'hBEEF);

    // Random traffic against the model, with two read-select changes per cycle.
    for (int t = 0; t < 300; t++) begin
      logic [2:0] a;
      logic [2:0] b;
      logic [W-1:0] din;
      din = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      do_cycle(($urandom_range(0, 15) == 0), 2'($urandom), 4'($urandom), 4'($urandom), din);
      a = 3'($urandom);
      b = 3'($urandom);
      read_check($sformatf("rand%0d_0", t), a, b, model[a], model[b]);
      a = 3'($urandom);
      b = a;
      read_check($sformatf("rand%0d_1", t), a, b, model[a], model[b]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: WIDTH, default 16, data width of every register, I, OutA and OutB.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 I  input  WIDTH  load data, shared by all registers.
REQ-005 FunSel  input  2  operation applied to every enabled register: 00 decrement, 01 increment, 10 load I, 11 clear.
REQ-006 RegSel  input  4  per-register enable for general registers R1..R4 (bit0=R1 ... bit3=R4), active-high.
REQ-007 ScrSel  input  4  per-register enable for scratch registers S1..S4 (bit0=S1 ... bit3=S4), active-high.
REQ-008 OutASel  input  3  read select, port A: 000..011 = R1..R4, 100..111 = S1..S4.
REQ-009 OutBSel  input  3  read select, port B, same encoding as OutASel.
REQ-010 OutA  output  WIDTH  contents of register chosen by OutASel.
REQ-011 OutB  output  WIDTH  contents of register chosen by OutBSel.

Function
REQ-012 Eight independent WIDTH-bit registers R1..R4, S1..S4 SHALL be held.
REQ-013 On a rising edge with Reset=0, each register whose enable bit is 1 SHALL apply FunSel; registers with enable 0 SHALL hold.
REQ-014 Any combination of enable bits SHALL be legal; all enabled registers SHALL apply the same FunSel in the same cycle.
REQ-015 Decrement and increment SHALL be modulo 2^WIDTH: 0x0000-1 = 0xFFFF, 0xFFFF+1 = 0x0000, no flag, no saturation.
REQ-016 Load SHALL capture I as sampled at the same rising edge.
REQ-017 OutA/OutB SHALL be combinational reads of current register contents, zero-cycle latency from select change.
REQ-018 A register written at edge N SHALL show the new value on OutA/OutB only after edge N; no write-through bypass.
REQ-019 OutASel and OutBSel SHALL select independently; both may address the same register and SHALL then return identical values.
REQ-020 The two read ports SHALL have no side effect on register state.

Reset
REQ-021 Reset=1 at a rising edge SHALL clear all eight registers to 0, regardless of RegSel, ScrSel and FunSel.
REQ-022 Reset SHALL have priority over any operation in progress in the same cycle; the operation SHALL be dropped, not deferred.
REQ-023 After reset, OutA and OutB SHALL read 0 for every select value.
REQ-024 Contents before the first reset SHALL be unspecified; the bench SHALL not check them.

Structure
REQ-025 A shared package SHALL define the FunSel encodings (FS_DEC=00, FS_INC=01, FS_LOAD=10, FS_CLR=11) and the 3-bit read-select codes (SEL_R1..SEL_S4).
REQ-026 One sub-module, gp_reg, SHALL implement a single register with Clock, Reset, E, FunSel and I; register_file SHALL instantiate it eight times.
REQ-027 Read muxes SHALL be in register_file; each decodes a 3-bit select to one of eight registers.

Verification
REQ-028 Reset=1 for one edge after random loads -> all eight OutASel/OutBSel values read 0x0000.
REQ-029 RegSel=0001, FunSel=10, I=0x1234; next cycle OutASel=000, OutBSel=100 -> OutA=0x1234, OutB=0x0000.
REQ-030 R2 cleared; RegSel=0010, FunSel=00 one edge -> R2=0xFFFF; FunSel=01 one edge -> R2=0x0000.
REQ-031 RegSel=1111, ScrSel=1111, FunSel=10, I=0xA5A5 -> all eight registers read 0xA5A5; then ScrSel=0100, FunSel=11 -> S3=0, rest unchanged at 0xA5A5.
REQ-032 S1=0x0010; ScrSel=0001, FunSel=01 with Reset=1 same edge -> S1=0x0000, not 0x0011.
REQ-033 OutASel=OutBSel=011 with R4=0x00FF, R4 loading 0xBEEF at edge N -> both ports 0x00FF before edge N, 0xBEEF after.
